mem_bus_arbiter: RTL and testbench

Two-requester arbiter that shares the single system memory port between the `cpu_armv4t` bus master and the DMA engine. Requests are granted one transfer at a time: DMA has fixed priority, bounded by a fairness counter so the CPU is never starved. A watchdog turns a missing slave acknowledge into an error completion. Sits between the masters and the memory/IO decoder. All data paths are unidirectional; tristating stays at the top level.

---
 rtl/mem_bus_arbiter_if.sv | 61 ++++++
 rtl/mem_bus_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_if
// Description : Bundle of the CPU, DMA and slave-side memory bus signals
//               around mem_bus_arbiter.
//               slave  - arbiter view (takes requests, drives the slave port)
//               master - environment view (requesters plus memory slave)
// Ports       : c_*  CPU request port, d_* DMA request port,
//               s_*  shared memory slave port, grant one-hot debug view
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if;
   logic [31:0] c_addr;
   logic [31:0] c_wdata;
   logic [1:0]  c_width;
   logic        c_read;
   logic        c_write;
   logic [31:0] c_rdata;
   logic        c_ok;
   logic        c_err;

   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [1:0]  d_width;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_rdata;
   logic        d_ok;
   logic        d_err;

   logic [31:0] s_addr;
   logic [31:0] s_wdata;
   logic [1:0]  s_width;
   logic        s_read;
   logic        s_write;
   logic [31:0] s_rdata;
   logic        s_ok;

   logic [1:0]  grant;

   modport slave (
      input  c_addr, c_wdata, c_width, c_read, c_write,
      output c_rdata, c_ok, c_err,
      input  d_addr, d_wdata, d_width, d_read, d_write,
      output d_rdata, d_ok, d_err,
      output s_addr, s_wdata, s_width, s_read, s_write,
      input  s_rdata, s_ok,
      output grant
   );

   modport master (
      output c_addr, c_wdata, c_width, c_read, c_write,
      input  c_rdata, c_ok, c_err,
      output d_addr, d_wdata, d_width, d_read, d_write,
      input  d_rdata, d_ok, d_err,
      input  s_addr, s_wdata, s_width, s_read, s_write,
      output s_rdata, s_ok,
      input  grant
   );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Two-requester (CPU / DMA) arbiter for the single memory port.
//               One transfer per grant, DMA priority limited by a run
//               counter, watchdog turns a missing s_ok into an error reply.
// Ports       : clk  - clock, all state on rising edge
//               rst  - synchronous active-high reset
//               bus  - mem_bus_arbiter_if.slave (CPU, DMA and slave ports)
// Parameters  : DMA_MAX_RUN - DMA grants allowed back-to-back while the
//                             CPU waits (1..255)
//               TIMEOUT     - GNT cycles allowed before abort (2..255)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
   parameter int DMA_MAX_RUN = 4,
   parameter int TIMEOUT     = 64
) (
   input  wire logic          clk,
   input  wire logic          rst,
   mem_bus_arbiter_if.slave   bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_GNT  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [7:0] C_MAX_RUN = 8'(DMA_MAX_RUN);
   localparam logic [7:0] C_WD_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic        r_own_dma;
   logic        w_own_dma_nxt;
   logic [7:0]  r_run_cnt;
   logic [7:0]  w_run_cnt_nxt;
   logic [7:0]  w_run_inc;
   logic [7:0]  r_wd;
   logic [7:0]  w_wd_nxt;

   logic        w_c_req;
   logic        w_d_req;
   logic        w_gnt_dma;
   logic        w_gnt_cpu;

   logic [31:0] w_m_addr;
   logic [31:0] w_m_wdata;
   logic [1:0]  w_m_width;
   logic        w_m_read;
   logic        w_m_write;

   logic        w_bad;
   logic        w_tmo;
   logic        w_fin;
   logic        w_fail;

   logic [31:0] w_s_addr;
   logic [31:0] w_s_wdata;
   logic [1:0]  w_s_width;
   logic        w_s_read;
   logic        w_s_write;
   logic [31:0] w_x_rdata;
   logic [1:0]  w_grant;

   assign w_c_req = bus.c_read | bus.c_write;
   assign w_d_req = bus.d_read | bus.d_write;

   // DMA wins unless the CPU is waiting and DMA has used up its run budget
   assign w_gnt_dma = w_d_req && (!w_c_req || (r_run_cnt < C_MAX_RUN));
   assign w_gnt_cpu = !w_gnt_dma && w_c_req;

   assign w_run_inc = (r_run_cnt == 8'hFF) ? r_run_cnt : r_run_cnt + 8'd1;

   // Granted master's request view
   assign w_m_addr  = r_own_dma ? bus.d_addr  : bus.c_addr;
   assign w_m_wdata = r_own_dma ? bus.d_wdata : bus.c_wdata;
   assign w_m_width = r_own_dma ? bus.d_width : bus.c_width;
   assign w_m_read  = r_own_dma ? bus.d_read  : bus.c_read;
   assign w_m_write = r_own_dma ? bus.d_write : bus.c_write;

   // Malformed request: never reaches the slave, answered immediately
   assign w_bad  = (w_m_width == 2'd3) || (w_m_read && w_m_write);
   // A real ack in the last watchdog cycle still completes normally
   assign w_tmo  = (r_wd == C_WD_LAST) && !bus.s_ok;
   assign w_fin  = (r_state == ST_GNT) && (w_bad || bus.s_ok || w_tmo);
   assign w_fail = (r_state == ST_GNT) && (w_bad || w_tmo);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_own_dma <= 1'b0;
         r_run_cnt <= 8'd0;
         r_wd      <= 8'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_own_dma <= w_own_dma_nxt;
         r_run_cnt <= w_run_cnt_nxt;
         r_wd      <= w_wd_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_own_dma_nxt = r_own_dma;
      w_run_cnt_nxt = r_run_cnt;
      w_wd_nxt      = r_wd;
      case (r_state)
         ST_IDLE: begin
            if (w_gnt_dma) begin
               w_state_nxt   = ST_GNT;
               w_own_dma_nxt = 1'b1;
               w_wd_nxt      = 8'd0;
               w_run_cnt_nxt = w_c_req ? w_run_inc : 8'd0;
            end else if (w_gnt_cpu) begin
               w_state_nxt   = ST_GNT;
               w_own_dma_nxt = 1'b0;
               w_wd_nxt      = 8'd0;
               w_run_cnt_nxt = 8'd0;
            end else begin
               // Reaching here means the CPU is not requesting
               w_run_cnt_nxt = 8'd0;
            end
         end
         ST_GNT: begin
            if (w_fin) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_wd_nxt = r_wd + 8'd1;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------
   always_comb begin
      w_s_addr  = 32'd0;
      w_s_wdata = 32'd0;
      w_s_width = 2'd0;
      w_s_read  = 1'b0;
      w_s_write = 1'b0;
      w_grant   = 2'b00;
      w_x_rdata = 32'd0;
      if (r_state == ST_GNT) begin
         w_grant   = r_own_dma ? 2'b10 : 2'b01;
         w_s_addr  = w_m_addr;
         w_s_wdata = w_m_wdata;
         w_s_width = w_m_width;
         if (!w_bad && !w_tmo) begin
            w_s_read  = w_m_read;
            w_s_write = w_m_write;
         end
         if (w_fin && !w_fail) begin
            w_x_rdata = bus.s_rdata;
         end
      end
   end

   assign bus.s_addr  = w_s_addr;
   assign bus.s_wdata = w_s_wdata;
   assign bus.s_width = w_s_width;
   assign bus.s_read  = w_s_read;
   assign bus.s_write = w_s_write;
   assign bus.grant   = w_grant;

   assign bus.c_ok    = w_fin  && !r_own_dma;
   assign bus.c_err   = w_fail && !r_own_dma;
   assign bus.c_rdata = r_own_dma ? 32'd0 : w_x_rdata;
   assign bus.d_ok    = w_fin  && r_own_dma;
   assign bus.d_err   = w_fail && r_own_dma;
   assign bus.d_rdata = r_own_dma ? w_x_rdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter. Plays both
//               requesters and a memory slave with a programmable number
//               of wait states; completions are matched against a queue of
//               expected replies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

   localparam int          P_MAX_RUN = 4;
   localparam int          P_TIMEOUT = 64;
   localparam logic [31:0] KEY       = 32'hA5A5_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_bus_arbiter_if bus ();

   mem_bus_arbiter #(
      .DMA_MAX_RUN (P_MAX_RUN),
      .TIMEOUT     (P_TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      bit          dma;
      bit          err;
      logic [31:0] rdata;
   } exp_t;
   exp_t sb[$];

   always @(negedge clk) begin
      exp_t e;
      if (!rst && (bus.c_ok || bus.d_ok)) begin
         check("ok_exclusive", 32'(bus.c_ok & bus.d_ok), 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_ok", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("sb_master", 32'(bus.d_ok), 32'(e.dma));
            check("sb_err", 32'(bus.d_ok ? bus.d_err : bus.c_err), 32'(e.err));
            check("sb_rdata", bus.d_ok ? bus.d_rdata : bus.c_rdata, e.rdata);
         end
      end
   end

   // ---------------- memory slave model ----------------
   int   slv_wait = 0;   // wait states before ack, -1 = never ack
   int   slv_cyc  = 0;
   logic force_ok = 1'b0;

   always @(posedge clk) begin
      #2;
      if (bus.s_read || bus.s_write) begin
         bus.s_ok = (slv_wait >= 0) && (slv_cyc == slv_wait);
         slv_cyc++;
      end else begin
         bus.s_ok = force_ok;
         slv_cyc  = 0;
      end
      bus.s_rdata = bus.s_addr ^ KEY;
   end

   // ---------------- vector table ----------------
   typedef struct {
      bit          dma;
      bit          rd;
      bit          wr;
      logic [1:0]  width;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          wt;
      bit          err;
      int          lat;   // negedges from request to ok (1 = the IDLE cycle)
      int          nstb;  // cycles with a slave strobe
   } vec_t;

   vec_t vt[8];

   task automatic drop_all();
      bus.c_read  = 1'b0;
      bus.c_write = 1'b0;
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      bit seen;
      int stb;
      bit in_win;
      seen = 1'b0;
      stb  = 0;
      if (v.dma) begin
         bus.d_addr = v.addr; bus.d_wdata = v.wdata; bus.d_width = v.width;
         bus.d_read = v.rd;   bus.d_write = v.wr;
      end else begin
         bus.c_addr = v.addr; bus.c_wdata = v.wdata; bus.c_width = v.width;
         bus.c_read = v.rd;   bus.c_write = v.wr;
      end
      slv_wait = v.wt;
      sb.push_back('{v.dma, v.err, v.err ? 32'd0 : (v.addr ^ KEY)});
      for (int n = 1; n <= P_TIMEOUT + 10; n++) begin
         @(negedge clk);
         if (bus.s_read || bus.s_write) stb++;
         in_win = (n >= 2) && (n < v.lat + (v.err ? 0 : 1));
         check("strobes", 32'({bus.s_read, bus.s_write}), in_win ? 32'({v.rd, v.wr}) : 32'd0);
         if (in_win) check("s_addr", bus.s_addr, v.addr);
         if (n == 2) check("grant", 32'(bus.grant), v.dma ? 32'd2 : 32'd1);
         if (v.dma ? bus.d_ok : bus.c_ok) begin
            seen = 1'b1;
            check("latency", 32'(n), 32'(v.lat));
            break;
         end
      end
      if (!seen) check("ok_wait_expired", 32'd0, 32'd1);
      check("strobe_cycles", 32'(stb), 32'(v.nstb));
      step();
      drop_all();
      step();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int          t1, t2, k;
      logic [9:0]  gseq;
      bus.c_addr = '0; bus.c_wdata = '0; bus.c_width = '0;
      bus.d_addr = '0; bus.d_wdata = '0; bus.d_width = '0;
      drop_all();
      bus.s_ok = 1'b0;
      bus.s_rdata = '0;

      vt[0] = '{0, 1, 0, 2'd2, 32'h0800_0000, 32'h0,          0, 0, 2, 1};
      vt[1] = '{0, 0, 1, 2'd1, 32'h0800_0104, 32'h0000_BEEF,  2, 0, 4, 3};
      vt[2] = '{1, 1, 0, 2'd0, 32'h2000_0003, 32'h0,          1, 0, 3, 2};
      vt[3] = '{1, 0, 1, 2'd2, 32'h2000_0010, 32'h1234_5678,  3, 0, 5, 4};
      vt[4] = '{0, 1, 0, 2'd3, 32'h0800_0200, 32'h0,          0, 1, 2, 0};
      vt[5] = '{1, 1, 1, 2'd2, 32'h2000_0020, 32'h55AA_55AA,  0, 1, 2, 0};
      vt[6] = '{0, 1, 0, 2'd2, 32'h0800_0300, 32'h0,          0, 0, 2, 1};
      vt[7] = '{1, 1, 0, 2'd2, 32'h2000_0040, 32'h0,         -1, 1, P_TIMEOUT + 1, P_TIMEOUT - 1};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_grant", 32'(bus.grant), 32'd0);
      check("rst_oks", 32'({bus.c_ok, bus.c_err, bus.d_ok, bus.d_err}), 32'd0);
      check("rst_strobes", 32'({bus.s_read, bus.s_write}), 32'd0);
      step();
      rst = 1'b0;
      step();

      for (int i = 0; i < 7; i++) run_vec(vt[i]);

      // Back-to-back CPU reads with the request held: one every 3 cycles
      bus.c_addr = 32'h0800_0400; bus.c_width = 2'd2; bus.c_read = 1'b1;
      slv_wait = 0;
      sb.push_back('{0, 0, 32'h0800_0400 ^ KEY});
      sb.push_back('{0, 0, 32'h0800_0400 ^ KEY});
      t1 = 0; t2 = 0; k = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (bus.c_ok) begin
            if (k == 0) t1 = n; else t2 = n;
            k++;
            if (k == 2) break;
         end
      end
      check("b2b_count", 32'(k), 32'd2);
      check("b2b_spacing", 32'(t2 - t1), 32'd3);
      step(); drop_all(); step();

      // Both masters requesting continuously
      bus.c_addr = 32'h0800_0100; bus.c_width = 2'd2;
      bus.d_addr = 32'h2000_0200; bus.d_width = 2'd2;
      for (int i = 0; i < 10; i++) begin
         if (i == 4 || i == 9) sb.push_back('{0, 0, 32'h0800_0100 ^ KEY});
         else                  sb.push_back('{1, 0, 32'h2000_0200 ^ KEY});
      end
      bus.c_read = 1'b1; bus.d_read = 1'b1;
      gseq = '0; k = 0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (bus.c_ok || bus.d_ok) begin
            gseq[k] = bus.d_ok;
            k++;
            if (k == 10) break;
         end
      end
      check("fair_count", 32'(k), 32'd10);
      check("fair_sequence", 32'(gseq), 32'(10'b01_1110_1111));
      step(); drop_all(); step();

      // DMA write with 5 wait states while the CPU waits
      bus.d_addr = 32'h3000_0010; bus.d_wdata = 32'hDEAD_BEEF; bus.d_width = 2'd1;
      bus.c_addr = 32'h0800_0040; bus.c_width = 2'd2;
      bus.d_write = 1'b1; bus.c_read = 1'b1;
      slv_wait = 5;
      sb.push_back('{1, 0, 32'h3000_0010 ^ KEY});
      sb.push_back('{0, 0, 32'h0800_0040 ^ KEY});
      for (int n = 1; n <= 7; n++) begin
         @(negedge clk);
         if (n >= 2) begin
            check("ws_s_addr", bus.s_addr, 32'h3000_0010);
            check("ws_s_wdata", bus.s_wdata, 32'hDEAD_BEEF);
            check("ws_s_width", 32'(bus.s_width), 32'd1);
         end
         check("ws_c_ok_low", 32'(bus.c_ok), 32'd0);
         if (n == 7) check("ws_d_ok", 32'(bus.d_ok), 32'd1);
      end
      step();
      bus.d_write = 1'b0;
      k = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (bus.c_ok) begin k = 1; break; end
      end
      check("ws_cpu_done", 32'(k), 32'd1);
      step(); drop_all(); step();

      // Reset in the 3rd wait cycle of a DMA write
      bus.d_addr = 32'h2000_0500; bus.d_wdata = 32'h0BAD_F00D; bus.d_width = 2'd2;
      bus.d_write = 1'b1;
      slv_wait = 20;
      step();         // GNT cycle 1
      step();         // GNT cycle 2
      step();         // GNT cycle 3
      rst = 1'b1;
      step();
      rst = 1'b0;
      drop_all();
      @(negedge clk);
      check("rstx_grant", 32'(bus.grant), 32'd0);
      check("rstx_strobes", 32'({bus.s_read, bus.s_write}), 32'd0);
      check("rstx_d_ok", 32'(bus.d_ok), 32'd0);
      step();
      run_vec(vt[6]);

      // Timeout, then a late ack that nobody may see
      run_vec(vt[7]);
      repeat (3) @(posedge clk);
      #1 force_ok = 1'b1;
      @(negedge clk);
      check("late_ack_oks", 32'({bus.c_ok, bus.d_ok}), 32'd0);
      step();
      force_ok = 1'b0;
      repeat (3) @(posedge clk);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
